// File: rtl/ddr_weight_reader.sv
// ddr_weight_reader: splits a DDR transfer into credit-gated read bursts feeding an FWFT weight FIFO.
// Define BURST_4K_SPLIT_EN to keep every burst inside one 4 KB address page.
module ddr_weight_reader #(
  parameter int DDR_ADDR_LEN = 32,
  parameter int DDR_DATA_LEN = 256,
  parameter int SINGLE_LEN   = 24,
  parameter int MAX_BURST    = 16,
  parameter int FIFO_DEPTH   = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ddr_conf,
  input  logic [DDR_ADDR_LEN-1:0] ddr_st_addr_out,
  input  logic [SINGLE_LEN-1:0]   ddr_len,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [DDR_ADDR_LEN-1:0] rd_addr,
  output logic [7:0]              rd_len,
  input  logic                    rd_data_valid,
  input  logic [DDR_DATA_LEN-1:0] rd_data,
  output logic                    ddr_fifo_empty,
  input  logic                    ddr_fifo_req,
  output logic [DDR_DATA_LEN-1:0] ddr_fifo_data,
  output logic                    idle,
  output logic                    err
);
  localparam int BPB = DDR_DATA_LEN / 8;
  localparam int OFS = $clog2(BPB);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CALC  = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;
  logic [1:0] state_q, state_d;
  logic [DDR_ADDR_LEN-1:0] addr_q, addr_d;
  logic [SINGLE_LEN-1:0] left_q, left_d, b_max, b;
  logic [CW-1:0] outst_q, outst_d, count_q, count_d, free;
  logic [AW-1:0] wr_q, rd_q;
  logic err_q;
  logic hs, push, pop;
  logic [DDR_DATA_LEN-1:0] mem [FIFO_DEPTH];
  assign b_max = (left_q > SINGLE_LEN'(MAX_BURST)) ? SINGLE_LEN'(MAX_BURST) : left_q;
`ifdef BURST_4K_SPLIT_EN
  logic [SINGLE_LEN-1:0] cap;
  assign cap = SINGLE_LEN'((13'h1000 - {1'b0, addr_q[11:0]}) >> OFS);
  assign b   = (cap < b_max) ? cap : b_max;
`else
  assign b = b_max;
`endif
  // Space not yet claimed by stored or in-flight beats; a burst only goes out if it fits.
  assign free           = CW'(FIFO_DEPTH) - count_q - outst_q;
  assign rd_valid       = (state_q == ISSUE) && (SINGLE_LEN'(free) >= b);
  assign rd_addr        = addr_q;
  assign rd_len         = rd_valid ? 8'(b) : 8'd0;
  assign hs             = rd_valid && rd_ready;
  assign push           = rd_data_valid && (outst_q != '0);
  assign ddr_fifo_empty = (count_q == '0);
  assign pop            = ddr_fifo_req && !ddr_fifo_empty;
  assign ddr_fifo_data  = ddr_fifo_empty ? '0 : mem[rd_q];
  assign idle           = (state_q == IDLE);
  assign err            = err_q;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    left_d  = left_q;
    outst_d = outst_q + (hs ? CW'(b) : '0) - CW'(push);
    count_d = count_q + CW'(push) - CW'(pop);
    case (state_q)
      IDLE: if (ddr_conf) begin
        state_d = CALC;
        addr_d  = ddr_st_addr_out & ~DDR_ADDR_LEN'(BPB - 1);
        left_d  = SINGLE_LEN'(({1'b0, ddr_len} + (SINGLE_LEN + 1)'(BPB - 1)) >> OFS);
      end
      CALC: state_d = (left_q == '0) ? IDLE : ISSUE;
      ISSUE: if (hs) begin
        addr_d  = addr_q + (DDR_ADDR_LEN'(b) << OFS);
        left_d  = left_q - b;
        state_d = (left_q == b) ? DRAIN : ISSUE;
      end
      default: state_d = (outst_q == '0) ? IDLE : DRAIN;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      left_q  <= '0;
      outst_q <= '0;
      count_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      left_q  <= left_d;
      outst_q <= outst_d;
      count_q <= count_d;
      wr_q    <= wr_q + AW'(push);
      rd_q    <= rd_q + AW'(pop);
      err_q   <= err_q | (rd_data_valid && (outst_q == '0));
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= rd_data;
  end
endmodule

// File: tb/tb_ddr_weight_reader.sv
// tb_ddr_weight_reader: directed bench with a DDR responder model and burst/data scoreboards.
module tb_ddr_weight_reader;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ddr_conf = 1'b0;
  logic [31:0]  st_addr = '0;
  logic [23:0]  len = '0;
  logic         rd_valid;
  logic         rd_ready = 1'b0;
  logic [31:0]  rd_addr;
  logic [7:0]   rd_len;
  logic         rd_data_valid = 1'b0;
  logic [255:0] rd_data = '0;
  logic         empty;
  logic         req = 1'b0;
  logic [255:0] fdata;
  logic         idle, err;
  int pass_cnt = 0, tot_cnt = 0, burst_cnt = 0, pop_cnt = 0, pop_budget = 0;
  int b0, p0;
  bit auto_ret = 1'b0;
  logic [31:0]  beat_id = 32'd1;
  logic [255:0] ret_q[$];
  logic [255:0] exp_q[$];
  logic [39:0]  burst_q[$];

  ddr_weight_reader dut (
    .clk(clk), .rst_n(rst_n), .ddr_conf(ddr_conf), .ddr_st_addr_out(st_addr), .ddr_len(len),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data), .ddr_fifo_empty(empty),
    .ddr_fifo_req(req), .ddr_fifo_data(fdata), .idle(idle), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tot_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Observe the handshake with this cycle's final inputs, cross the edge, then drive the next cycle.
  task automatic tick();
    if (rd_valid && rd_ready) begin
      burst_cnt++;
      if (burst_q.size() > 0) chk("burst", {rd_addr, rd_len}, burst_q.pop_front());
      for (int i = 0; i < int'(rd_len); i++) begin
        ret_q.push_back({8{beat_id}});
        beat_id++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    rd_data_valid = 1'b0;
    req = 1'b0;
    if (auto_ret && ret_q.size() > 0) begin
      rd_data = ret_q.pop_front();
      rd_data_valid = 1'b1;
      exp_q.push_back(rd_data);
    end
    if (pop_budget > 0 && !empty) begin
      chk("pop_data", fdata, (exp_q.size() > 0) ? exp_q.pop_front() : 256'bx);
      req = 1'b1;
      pop_budget--;
      pop_cnt++;
    end
  endtask

  task automatic conf(input logic [31:0] a, input logic [23:0] l);
    st_addr = a;
    len = l;
    ddr_conf = 1'b1;
    tick();
    ddr_conf = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (idle && empty && ret_q.size() == 0 && exp_q.size() == 0 && burst_q.size() == 0) break;
      tick();
    end
    chk("done", {idle, empty, ret_q.size() == 0, exp_q.size() == 0, burst_q.size() == 0}, 5'b11111);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd_valid"}, rd_valid, 1'b0);
    chk({tag, "_rd_addr"}, rd_addr, 32'h0);
    chk({tag, "_rd_len"}, rd_len, 8'h0);
    chk({tag, "_empty"}, empty, 1'b1);
    chk({tag, "_fdata"}, fdata, 256'h0);
    chk({tag, "_idle"}, idle, 1'b1);
    chk({tag, "_err"}, err, 1'b0);
  endtask

  initial begin
    repeat (3) tick();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    tick();
    // basic transfer: two full bursts, immediate returns and pops
    rd_ready = 1'b1;
    auto_ret = 1'b1;
    pop_budget = 100000;
    b0 = burst_cnt;
    p0 = pop_cnt;
    burst_q.push_back({32'h1000, 8'd16});
    burst_q.push_back({32'h1200, 8'd16});
    conf(32'h1000, 24'd1024);
    chk("conf_idle_low", idle, 1'b0);
    tick();
    chk("first_rd_valid", rd_valid, 1'b1);
    wait_done(300);
    chk("basic_bursts", burst_cnt - b0, 2);
    chk("basic_pops", pop_cnt - p0, 32);
    chk("basic_err", err, 1'b0);
    // rounding and alignment
    b0 = burst_cnt;
    burst_q.push_back({32'h1000, 8'd2});
    conf(32'h1007, 24'd33);
    wait_done(100);
    chk("round_bursts", burst_cnt - b0, 1);
    // zero length
    b0 = burst_cnt;
    conf(32'h1000, 24'd0);
    chk("zero_idle_t1", idle, 1'b0);
    chk("zero_valid_t1", rd_valid, 1'b0);
    tick();
    chk("zero_idle_t2", idle, 1'b1);
    repeat (3) tick();
    chk("zero_bursts", burst_cnt - b0, 0);
    // credit: no pops, only the FIFO's worth of bursts may go out
    pop_budget = 0;
    b0 = burst_cnt;
    p0 = pop_cnt;
    for (int i = 0; i < 8; i++) burst_q.push_back({32'h2000 + 32'(i) * 32'h200, 8'd16});
    conf(32'h2000, 24'd4096);
    repeat (100) tick();
    chk("credit_bursts", burst_cnt - b0, 4);
    chk("credit_valid_low", rd_valid, 1'b0);
    chk("credit_full", empty, 1'b0);
    rd_ready = 1'b0;
    pop_budget = 16;
    repeat (20) tick();
    chk("credit_release", rd_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_addr", rd_addr, 32'h2800);
      chk("stall_len", rd_len, 8'd16);
    end
    chk("stall_bursts", burst_cnt - b0, 4);
    rd_ready = 1'b1;
    pop_budget = 100000;
    wait_done(600);
    chk("credit_total_bursts", burst_cnt - b0, 8);
    chk("credit_total_pops", pop_cnt - p0, 128);
    chk("credit_err", err, 1'b0);
    // 4 KB boundary
    b0 = burst_cnt;
`ifdef BURST_4K_SPLIT_EN
    burst_q.push_back({32'h0FC0, 8'd2});
    burst_q.push_back({32'h1000, 8'd14});
    conf(32'h0FC0, 24'd512);
    wait_done(200);
    chk("split_bursts", burst_cnt - b0, 2);
`else
    burst_q.push_back({32'h0FC0, 8'd16});
    conf(32'h0FC0, 24'd512);
    wait_done(200);
    chk("nosplit_bursts", burst_cnt - b0, 1);
`endif
    // ddr_conf while busy is ignored
    auto_ret = 1'b0;
    b0 = burst_cnt;
    p0 = pop_cnt;
    burst_q.push_back({32'h3000, 8'd2});
    conf(32'h3000, 24'd64);
    conf(32'h5000, 24'd1024);
    repeat (5) tick();
    conf(32'h6000, 24'd64);
    chk("busy_idle", idle, 1'b0);
    auto_ret = 1'b1;
    wait_done(100);
    chk("busy_bursts", burst_cnt - b0, 1);
    chk("busy_pops", pop_cnt - p0, 2);
    // stray beat in IDLE
    rd_data = {8{32'hDEAD_BEEF}};
    rd_data_valid = 1'b1;
    tick();
    tick();
    chk("stray_err", err, 1'b1);
    chk("stray_empty", empty, 1'b1);
    // reset mid-transfer
    auto_ret = 1'b0;
    pop_budget = 0;
    burst_q.push_back({32'h4000, 8'd16});
    conf(32'h4000, 24'd2048);
    repeat (4) tick();
    auto_ret = 1'b1;
    repeat (4) tick();
    auto_ret = 1'b0;
    tick();
    chk("pre_reset_fill", empty, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_reset");
    ret_q.delete();
    exp_q.delete();
    burst_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_empty", empty, 1'b1);
    chk("post_reset_idle", idle, 1'b1);
    rd_data_valid = 1'b1;
    tick();
    tick();
    chk("late_beat_err", err, 1'b1);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
